// File: rtl/credit_display_driver.sv
// rtl/credit_display_driver.sv - binary credit value to scanned BCD digits for seven_segment
//
// Converts a 0..999 binary value (saturated above 999) into three BCD digits with a
// sequential double-dabble engine, then time-multiplexes the committed digits onto
// the number bus with a one-hot digit enable. Leading zeros are blanked.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   load      in   convert request, sampled only while busy=0
//   value     in   10-bit unsigned binary value
//   busy      out  conversion in progress
//   number    out  BCD digit of the current scan slot
//   digit_en  out  one-hot slot enable (bit0 units, bit1 tens, bit2 hundreds), 0 when blanked
//   overflow  out  last committed value exceeded 999
module credit_display_driver #(
  parameter int REFRESH_DIV = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [9:0] value,
  output logic       busy,
  output logic [3:0] number,
  output logic [2:0] digit_en,
  output logic       overflow
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [RW-1:0] RMAX = RW'(REFRESH_DIV - 1);

  state_t      state, state_d;
  logic        accept, do_shift, do_commit;

  logic [3:0]  shift_cnt;
  logic [9:0]  bin_w;
  logic [11:0] bcd_w;
  logic        ovf_pend;

  logic [11:0] bcd_adj;
  logic [11:0] bcd_next;
  logic [9:0]  bin_next;

  logic [3:0]  dig0, dig1, dig2;

  logic [RW-1:0] rcnt;
  logic [1:0]    slot;
  logic          blank1, blank2;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // FSM next-state and datapath strobes
  always_comb begin
    state_d   = state;
    accept    = 1'b0;
    do_shift  = 1'b0;
    do_commit = 1'b0;
    case (state)
      IDLE: begin
        if (load) begin
          accept  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        do_shift = 1'b1;
        // shift_cnt counts completed steps; the step taken at count 9 is the tenth
        if (shift_cnt == 4'd9) begin
          state_d = COMMIT;
        end
      end
      COMMIT: begin
        do_commit = 1'b1;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy = (state != IDLE);

  // One double-dabble step: add 3 to every nibble >= 5, then shift {bcd, bin} left
  always_comb begin
    bcd_adj        = bcd_w;
    if (bcd_w[3:0]  >= 4'd5) bcd_adj[3:0]  = bcd_w[3:0]  + 4'd3;
    if (bcd_w[7:4]  >= 4'd5) bcd_adj[7:4]  = bcd_w[7:4]  + 4'd3;
    if (bcd_w[11:8] >= 4'd5) bcd_adj[11:8] = bcd_w[11:8] + 4'd3;
    bcd_next = {bcd_adj[10:0], bin_w[9]};
    bin_next = {bin_w[8:0], 1'b0};
  end

  // Conversion datapath and committed display registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_cnt <= 4'd0;
      bin_w     <= 10'd0;
      bcd_w     <= 12'd0;
      ovf_pend  <= 1'b0;
      dig0      <= 4'd0;
      dig1      <= 4'd0;
      dig2      <= 4'd0;
      overflow  <= 1'b0;
    end else begin
      if (accept) begin
        bin_w     <= (value > 10'd999) ? 10'd999 : value;
        ovf_pend  <= (value > 10'd999);
        bcd_w     <= 12'd0;
        shift_cnt <= 4'd0;
      end
      if (do_shift) begin
        bcd_w     <= bcd_next;
        bin_w     <= bin_next;
        shift_cnt <= shift_cnt + 4'd1;
      end
      if (do_commit) begin
        dig0     <= bcd_w[3:0];
        dig1     <= bcd_w[7:4];
        dig2     <= bcd_w[11:8];
        overflow <= ovf_pend;
      end
    end
  end

  // Scan timing, free-running and independent of the conversion FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rcnt <= '0;
      slot <= 2'd0;
    end else begin
      if (rcnt == RMAX) begin
        rcnt <= '0;
        slot <= (slot == 2'd2) ? 2'd0 : slot + 2'd1;
      end else begin
        rcnt <= rcnt + 1'b1;
      end
    end
  end

  // Tens is blanked only when the hundreds is also blank, so 105 still shows its 0
  assign blank2 = (dig2 == 4'd0);
  assign blank1 = blank2 && (dig1 == 4'd0);

  always_comb begin
    number   = 4'd0;
    digit_en = 3'b000;
    case (slot)
      2'd0: begin
        number   = dig0;
        digit_en = 3'b001;
      end
      2'd1: begin
        number   = dig1;
        digit_en = blank1 ? 3'b000 : 3'b010;
      end
      2'd2: begin
        number   = dig2;
        digit_en = blank2 ? 3'b000 : 3'b100;
      end
      default: begin
        number   = 4'd0;
        digit_en = 3'b000;
      end
    endcase
  end

endmodule

// File: tb/tb_credit_display_driver.sv
// tb/tb_credit_display_driver.sv - table-driven bench for credit_display_driver
module tb_credit_display_driver;

  logic       clk;
  logic       rst_n;
  logic       load;
  logic [9:0] value;
  logic       busy;
  logic [3:0] number;
  logic [2:0] digit_en;
  logic       overflow;

  int checks;
  int failures;

  typedef struct {
    logic [9:0]  value;
    logic [11:0] nums;  // expected number per slot {hundreds, tens, units}
    logic [8:0]  ens;   // expected digit_en per slot {slot2, slot1, slot0}
    logic        ovf;
  } vec_t;

  vec_t vecs[8];
  vec_t zero_vec;

  // Expected scan position: each slot held for 4 cycles, 0->1->2->0
  int m_cnt;
  int m_slot;

  credit_display_driver #(.REFRESH_DIV(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .value    (value),
    .busy     (busy),
    .number   (number),
    .digit_en (digit_en),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #25 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt  <= 0;
      m_slot <= 0;
    end else if (m_cnt == 3) begin
      m_cnt  <= 0;
      m_slot <= (m_slot == 2) ? 0 : m_slot + 1;
    end else begin
      m_cnt <= m_cnt + 1;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic check_frame(input vec_t v, input string tag);
    logic [3:0] en_num;
    logic [2:0] en_exp;
    for (int c = 0; c < 12; c++) begin
      en_num = v.nums[m_slot*4 +: 4];
      en_exp = v.ens[m_slot*3 +: 3];
      chk($sformatf("%s cyc%0d slot%0d number", tag, c, m_slot), int'(number), int'(en_num));
      chk($sformatf("%s cyc%0d slot%0d digit_en", tag, c, m_slot), int'(digit_en), int'(en_exp));
      @(negedge clk);
    end
  endtask

  // Pulse load for one edge, then measure busy length and check the committed frame
  task automatic run_vec(input vec_t v, input string tag);
    int cnt;
    @(negedge clk);
    load  = 1'b1;
    value = v.value;
    @(negedge clk);
    load  = 1'b0;
    cnt   = 0;
    while (busy && cnt < 40) begin
      cnt++;
      @(negedge clk);
    end
    chk({tag, " busy_cycles"}, cnt, 11);
    chk({tag, " overflow"}, int'(overflow), int'(v.ovf));
    check_frame(v, tag);
  endtask

  initial begin
    int cnt;
    checks   = 0;
    failures = 0;

    vecs[0] = '{value: 10'd437,  nums: 12'h437, ens: 9'b100_010_001, ovf: 1'b0};
    vecs[1] = '{value: 10'd5,    nums: 12'h005, ens: 9'b000_000_001, ovf: 1'b0};
    vecs[2] = '{value: 10'd0,    nums: 12'h000, ens: 9'b000_000_001, ovf: 1'b0};
    vecs[3] = '{value: 10'd1023, nums: 12'h999, ens: 9'b100_010_001, ovf: 1'b1};
    vecs[4] = '{value: 10'd250,  nums: 12'h250, ens: 9'b100_010_001, ovf: 1'b0};
    vecs[5] = '{value: 10'd10,   nums: 12'h010, ens: 9'b000_010_001, ovf: 1'b0};
    vecs[6] = '{value: 10'd100,  nums: 12'h100, ens: 9'b100_010_001, ovf: 1'b0};
    vecs[7] = '{value: 10'd1000, nums: 12'h999, ens: 9'b100_010_001, ovf: 1'b1};
    zero_vec = '{value: 10'd0, nums: 12'h000, ens: 9'b000_000_001, ovf: 1'b0};

    rst_n = 1'b0;
    load  = 1'b0;
    value = 10'd0;
    #1;
    chk("reset number", int'(number), 0);
    chk("reset digit_en", int'(digit_en), 1);
    chk("reset busy", int'(busy), 0);
    chk("reset overflow", int'(overflow), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_frame(zero_vec, "post_reset");

    for (int i = 0; i < 8; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d_%0d", i, vecs[i].value));
    end

    // Reset in the middle of a conversion, with overflow and a 999 display pending
    @(negedge clk);
    load  = 1'b1;
    value = 10'd999;
    @(negedge clk);
    load = 1'b0;
    repeat (3) @(negedge clk);
    chk("midshift busy", int'(busy), 1);
    #5 rst_n = 1'b0;
    #1;
    chk("async_reset busy", int'(busy), 0);
    chk("async_reset overflow", int'(overflow), 0);
    chk("async_reset number", int'(number), 0);
    chk("async_reset digit_en", int'(digit_en), 1);
    @(negedge clk);
    rst_n = 1'b1;
    check_frame(zero_vec, "after_async_reset");
    run_vec(vecs[4], "post_reset_250");

    // Second load while busy must be dropped
    @(negedge clk);
    load  = 1'b1;
    value = 10'd437;
    @(negedge clk);
    load = 1'b0;
    cnt  = 0;
    while (busy && cnt < 40) begin
      if (cnt == 2) begin
        load  = 1'b1;
        value = 10'd123;
      end else begin
        load = 1'b0;
      end
      cnt++;
      @(negedge clk);
    end
    load = 1'b0;
    chk("ignored_load busy_cycles", cnt, 11);
    chk("ignored_load overflow", int'(overflow), 0);
    check_frame(vecs[0], "ignored_load");
    chk("ignored_load no_restart busy", int'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
